uart_tx_cfg: RTL
================

// Module: uart_tx_cfg
// PURPOSE
//   Parametrised UART transmitter for the FPGA board designs. Serialises one word per
//   valid/ready handshake into a start bit, 5-9 data bits (LSB first), optional odd/even
//   parity and 1 or 2 stop bits. Sits between a byte source (FIFO, command logic) and
//   the board TX pin. Provides back-pressure (tx_ready), a frame-complete pulse and a busy flag.
// PARAMETERS
//   CLK_FREQ   50000000  system clock frequency, Hz
//   UART_BPS   9600      baud rate; bit period BPS_CNT = CLK_FREQ/UART_BPS (integer, truncated)
//   DATA_BITS  8         data bits per frame, legal 5..9
//   PARITY     0         0 = none, 1 = odd, 2 = even
//   STOP_BITS  1         stop bits, legal 1..2
// PORTS
//   clk        in   1          system clock, all logic on rising edge
//   rst_n      in   1          asynchronous reset, active low
//   tx_valid   in   1          source has a word on tx_data
//   tx_data    in   DATA_BITS  word to send, sampled only on handshake
//   tx_ready   out  1          block can accept a word (high only in IDLE)
//   uart_tx    out  1          serial line, idle high
//   tx_busy    out  1          frame in progress (START..STOP)
//   tx_done    out  1          one-cycle pulse, frame finished
// BEHAVIOUR
//   - One clock (clk); reset is asynchronous and active-low (rst_n). All outputs registered.
//   - Reset values: uart_tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, counters=0.
//   - Reset mid-frame: frame aborted at once, line forced high; no tx_done for aborted frame.
//   - Handshake: accept when tx_valid & tx_ready at a rising edge (cycle T); tx_data latched
//     into a shift register then. tx_valid while busy is ignored; tx_data may change freely.
//   - FSM: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
//     IDLE:   uart_tx=1, tx_ready=1; on handshake go to START.
//     START:  uart_tx=0 for BPS_CNT clocks.
//     DATA:   DATA_BITS bits, LSB first, BPS_CNT clocks each; bit index counter 0..DATA_BITS-1.
//     PARITY: odd -> ~^data, even -> ^data, over the latched DATA_BITS; BPS_CNT clocks.
//     STOP:   uart_tx=1 for STOP_BITS*BPS_CNT clocks.
//   - Latency: start bit appears at T+1. Every bit exactly BPS_CNT clocks; baud counter
//     width $clog2(BPS_CNT), counts 0..BPS_CNT-1 then wraps and advances bit/state.
//   - Frame length F = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*BPS_CNT clocks (T+1..T+F).
//   - At T+F+1: state IDLE, tx_ready=1, tx_busy=0, tx_done=1 for exactly that cycle.
//   - Back-to-back: tx_valid held high is accepted in the tx_done cycle; next start bit at
//     T+F+2, i.e. exactly one idle-high clock between frames.
//   - tx_busy = 1 from T+1 through T+F inclusive.
//   - Illegal DATA_BITS/PARITY/STOP_BITS or BPS_CNT<2: elaboration-time $error.
// TESTING (sim: CLK_FREQ=50000000, UART_BPS=5000000 -> BPS_CNT=10)
//   8N1, send 8'h55 -> line 0,1,0,1,0,1,0,1,0,1 each 10 clk from T+1; tx_done at T+101.
//   8E1 send 8'h07 -> parity bit 1; 8O2 send 8'h07 -> parity bit 0, stop high 20 clk, done T+121.
//   8N1, tx_valid held, words 8'hA5 then 8'h3C -> 2nd accept in tx_done cycle, 1-clk gap, both decode.
//   tx_valid pulsed with 8'hFF at T+40 while busy -> ignored, tx_ready=0, line still carries first word.
//   rst_n low during data bit 3 -> uart_tx=1 immediately, tx_done never pulses; next frame 8'h81 correct.
//   DATA_BITS=5 send 5'h13 and DATA_BITS=9 send 9'h1FF -> correct bit count, F=70/110 clk.

Source files
------------

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_cfg
//  Purpose  : Parametrised UART transmitter. Accepts one word per valid/ready
//             handshake and serialises it as start bit, DATA_BITS data bits
//             (LSB first), optional odd/even parity and 1 or 2 stop bits.
//  Ports    : clk      - system clock, rising edge
//             rst_n    - asynchronous reset, active low
//             tx_valid - source presents a word on tx_data
//             tx_data  - word to send, sampled only on handshake
//             tx_ready - block can accept a word (IDLE only)
//             uart_tx  - serial line, idle high
//             tx_busy  - frame in progress
//             tx_done  - one-cycle pulse after the last stop bit
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
   parameter int CLK_FREQ  = 50000000,
   parameter int UART_BPS  = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 uart_tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int BPS_CNT = CLK_FREQ / UART_BPS;
   localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
   localparam int IDX_W   = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] c_BAUD_MAX = CNT_W'(BPS_CNT - 1);
   localparam logic [IDX_W-1:0] c_IDX_MAX  = IDX_W'(DATA_BITS - 1);
   localparam logic             c_STOP_MAX = 1'(STOP_BITS - 1);

   localparam logic [2:0] c_S_IDLE   = 3'd0;
   localparam logic [2:0] c_S_START  = 3'd1;
   localparam logic [2:0] c_S_DATA   = 3'd2;
   localparam logic [2:0] c_S_PARITY = 3'd3;
   localparam logic [2:0] c_S_STOP   = 3'd4;

   generate
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
         $error("uart_tx_cfg: DATA_BITS must be 5..9");
      end
      if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
         $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
         $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
      end
      if (BPS_CNT < 2) begin : g_bad_bps_cnt
         $error("uart_tx_cfg: CLK_FREQ/UART_BPS must be at least 2");
      end
   endgenerate

   logic [2:0]           r_state;
   logic [CNT_W-1:0]     r_baud_cnt;
   logic [IDX_W-1:0]     r_bit_idx;
   logic                 r_stop_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_parity;
   logic                 r_tx;
   logic                 r_ready;
   logic                 r_busy;
   logic                 r_done;
   logic                 w_baud_wrap;

   assign w_baud_wrap = (r_baud_cnt == c_BAUD_MAX);

   // Every output is registered, so each branch loads the line value that
   // must be visible during the bit period starting at this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= c_S_IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_stop_cnt <= 1'b0;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_tx       <= 1'b1;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            c_S_IDLE: begin
               r_tx    <= 1'b1;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               if (tx_valid && r_ready) begin
                  r_state    <= c_S_START;
                  r_shift    <= tx_data;
                  // odd parity: bit makes total ones odd; even: total even
                  r_parity   <= (PARITY == 1) ? ~^tx_data : ^tx_data;
                  r_baud_cnt <= '0;
                  r_tx       <= 1'b0;
                  r_ready    <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            c_S_START: begin
               if (w_baud_wrap) begin
                  r_baud_cnt <= '0;
                  r_bit_idx  <= '0;
                  r_state    <= c_S_DATA;
                  r_tx       <= r_shift[0];
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end
            c_S_DATA: begin
               if (w_baud_wrap) begin
                  r_baud_cnt <= '0;
                  if (r_bit_idx == c_IDX_MAX) begin
                     r_stop_cnt <= 1'b0;
                     if (PARITY != 0) begin
                        r_state <= c_S_PARITY;
                        r_tx    <= r_parity;
                     end else begin
                        r_state <= c_S_STOP;
                        r_tx    <= 1'b1;
                     end
                  end else begin
                     // shift register keeps the next bit at position 1
                     r_bit_idx <= r_bit_idx + 1'b1;
                     r_shift   <= r_shift >> 1;
                     r_tx      <= r_shift[1];
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end
            c_S_PARITY: begin
               if (w_baud_wrap) begin
                  r_baud_cnt <= '0;
                  r_stop_cnt <= 1'b0;
                  r_state    <= c_S_STOP;
                  r_tx       <= 1'b1;
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end
            c_S_STOP: begin
               if (w_baud_wrap) begin
                  r_baud_cnt <= '0;
                  if (r_stop_cnt == c_STOP_MAX) begin
                     r_state <= c_S_IDLE;
                     r_tx    <= 1'b1;
                     r_ready <= 1'b1;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_stop_cnt <= r_stop_cnt + 1'b1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= c_S_IDLE;
               r_tx    <= 1'b1;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_ready = r_ready;
   assign uart_tx  = r_tx;
   assign tx_busy  = r_busy;
   assign tx_done  = r_done;

endmodule
`default_nettype wire
